// File: rtl/comp_strg_responder_if.sv
// Command/handshake bundle between the comp-storage initiator and responder.
// DQ is carried as a separate inout port on the responder.
interface comp_strg_responder_if #(
    parameter int STRG_ADDRESS_WIDTH = 4
);
    logic                          en;
    logic [1:0]                    cmd;
    logic [STRG_ADDRESS_WIDTH-1:0] addA;
    logic [STRG_ADDRESS_WIDTH-1:0] addB;
    logic [STRG_ADDRESS_WIDTH-1:0] addC;
    logic                          valid_out;
    logic                          busy;

    modport master (
        output en, cmd, addA, addB, addC,
        input  valid_out, busy
    );

    modport slave (
        input  en, cmd, addA, addB, addC,
        output valid_out, busy
    );
endinterface

// File: rtl/comp_strg_responder.sv
// Storage/compute responder: register-file memory with WRITE/READ/ADD/SUB commands,
// returning read and ALU data on the shared tri-state DQ bus.
module comp_strg_responder #(
    parameter int STRG_ADDRESS_WIDTH = 4,
    parameter int STRG_DATA_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    comp_strg_responder_if.slave       bus,
    inout  wire [STRG_DATA_WIDTH-1:0]  DQ
);
    localparam int DEPTH = 2 ** STRG_ADDRESS_WIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_DRV = 2'd1;
    localparam logic [1:0] ALU_EX = 2'd2;
    localparam logic [1:0] ALU_WB = 2'd3;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;

    logic [1:0]                    state;
    logic                          wr_done;
    logic [STRG_ADDRESS_WIDTH-1:0] rd_addr;
    logic [STRG_ADDRESS_WIDTH-1:0] addr_c;
    logic [STRG_DATA_WIDTH-1:0]    op_a;
    logic [STRG_DATA_WIDTH-1:0]    op_b;
    logic [STRG_DATA_WIDTH-1:0]    result;
    logic                          op_sub;
    logic [STRG_DATA_WIDTH-1:0]    mem [DEPTH];

    logic                          drive;
    logic [STRG_DATA_WIDTH-1:0]    drive_data;

    // Operands are captured at accept so an ALU result aliasing an operand address
    // still computes from the pre-command contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_done <= 1'b0;
            rd_addr <= '0;
            addr_c  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
            op_sub  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        case (bus.cmd)
                            CMD_WRITE: begin
                                mem[bus.addA] <= DQ;
                                wr_done       <= 1'b1;
                            end
                            CMD_READ: begin
                                rd_addr <= bus.addA;
                                state   <= RD_DRV;
                            end
                            default: begin
                                op_a   <= mem[bus.addA];
                                op_b   <= mem[bus.addB];
                                addr_c <= bus.addC;
                                op_sub <= bus.cmd[0];
                                state  <= ALU_EX;
                            end
                        endcase
                    end
                end
                RD_DRV: state <= IDLE;
                ALU_EX: begin
                    result <= op_sub ? (op_a - op_b) : (op_a + op_b);
                    state  <= ALU_WB;
                end
                ALU_WB: begin
                    mem[addr_c] <= result;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // WRITE completes while already back in IDLE, so its pulse comes from wr_done.
    assign drive         = (state == RD_DRV) || (state == ALU_WB);
    assign drive_data    = (state == RD_DRV) ? mem[rd_addr] : result;
    assign bus.valid_out = wr_done || drive;
    assign bus.busy      = (state != IDLE);
    assign DQ            = drive ? drive_data : 'z;

endmodule

// File: tb/tb_comp_strg_responder.sv
// Directed bench for comp_strg_responder: vector table plus reset, busy-drop
// and pipelined-write sequences.
module tb_comp_strg_responder;
    localparam logic [1:0] WR  = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] ADD = 2'b10;
    localparam logic [1:0] SUB = 2'b11;

    typedef struct {
        logic [1:0]  cmd;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  c;
        logic [15:0] wdata;
        logic [15:0] expd;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] tb_dq;
    logic        tb_dq_en;
    wire  [15:0] dq;
    int          checks;
    int          errors;
    int          pulses;
    vec_t        vecs [16];

    comp_strg_responder_if #(.STRG_ADDRESS_WIDTH(4)) bus ();

    comp_strg_responder #(
        .STRG_ADDRESS_WIDTH(4),
        .STRG_DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .DQ(dq)
    );

    assign dq = tb_dq_en ? tb_dq : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Presents one command for a single accept edge, then returns #1 after that edge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] c,
                                 input logic [15:0] wdata);
        bus.en   = 1'b1;
        bus.cmd  = cmd;
        bus.addA = a;
        bus.addB = b;
        bus.addC = c;
        tb_dq    = wdata;
        tb_dq_en = (cmd == WR);
        @(posedge clk);
        #1;
        bus.en   = 1'b0;
        tb_dq_en = 1'b0;
    endtask

    task automatic runVector(input logic [1:0] cmd, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] c,
                             input logic [15:0] wdata, input logic [15:0] expd);
        applyStimulus(cmd, a, b, c, wdata);
        if (cmd == WR) begin
            checkOutput("wr_valid", {15'd0, bus.valid_out}, 16'd1);
            checkOutput("wr_busy", {15'd0, bus.busy}, 16'd0);
            @(posedge clk);
            #1;
            checkOutput("wr_valid_end", {15'd0, bus.valid_out}, 16'd0);
        end else if (cmd == RD) begin
            checkOutput("rd_valid", {15'd0, bus.valid_out}, 16'd1);
            checkOutput("rd_busy", {15'd0, bus.busy}, 16'd1);
            checkOutput("rd_dq", dq, expd);
            @(posedge clk);
            #1;
            checkOutput("rd_valid_end", {15'd0, bus.valid_out}, 16'd0);
            checkOutput("rd_busy_end", {15'd0, bus.busy}, 16'd0);
        end else begin
            checkOutput("alu_valid_early", {15'd0, bus.valid_out}, 16'd0);
            checkOutput("alu_busy_ex", {15'd0, bus.busy}, 16'd1);
            @(posedge clk);
            #1;
            checkOutput("alu_valid", {15'd0, bus.valid_out}, 16'd1);
            checkOutput("alu_dq", dq, expd);
            @(posedge clk);
            #1;
            checkOutput("alu_valid_end", {15'd0, bus.valid_out}, 16'd0);
            checkOutput("alu_busy_end", {15'd0, bus.busy}, 16'd0);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        vecs[0]  = '{WR,  4'd3, 4'd0, 4'd0, 16'hBEEF, 16'h0000};
        vecs[1]  = '{RD,  4'd3, 4'd0, 4'd0, 16'h0000, 16'hBEEF};
        vecs[2]  = '{WR,  4'd1, 4'd0, 4'd0, 16'hFFFF, 16'h0000};
        vecs[3]  = '{WR,  4'd2, 4'd0, 4'd0, 16'h0002, 16'h0000};
        vecs[4]  = '{ADD, 4'd1, 4'd2, 4'd5, 16'h0000, 16'h0001};
        vecs[5]  = '{RD,  4'd5, 4'd0, 4'd0, 16'h0000, 16'h0001};
        vecs[6]  = '{WR,  4'd1, 4'd0, 4'd0, 16'h0003, 16'h0000};
        vecs[7]  = '{WR,  4'd2, 4'd0, 4'd0, 16'h0005, 16'h0000};
        vecs[8]  = '{SUB, 4'd1, 4'd2, 4'd1, 16'h0000, 16'hFFFE};
        vecs[9]  = '{RD,  4'd1, 4'd0, 4'd0, 16'h0000, 16'hFFFE};
        vecs[10] = '{RD,  4'd2, 4'd0, 4'd0, 16'h0000, 16'h0005};
        vecs[11] = '{ADD, 4'd5, 4'd3, 4'd7, 16'h0000, 16'hBEF0};
        vecs[12] = '{RD,  4'd7, 4'd0, 4'd0, 16'h0000, 16'hBEF0};
        vecs[13] = '{SUB, 4'd6, 4'd3, 4'd6, 16'h0000, 16'h4111};
        vecs[14] = '{RD,  4'd6, 4'd0, 4'd0, 16'h0000, 16'h4111};
        vecs[15] = '{RD,  4'd15, 4'd0, 4'd0, 16'h0000, 16'h0000};

        rst      = 1'b0;
        bus.en   = 1'b0;
        bus.cmd  = 2'b00;
        bus.addA = '0;
        bus.addB = '0;
        bus.addC = '0;
        tb_dq    = '0;
        tb_dq_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {15'd0, bus.valid_out}, 16'd0);
        checkOutput("reset_busy", {15'd0, bus.busy}, 16'd0);
        rst = 1'b1;

        // Reset landing in ALU_EX must abort the command and clear memory.
        runVector(WR, 4'd4, 4'd0, 4'd0, 16'h1234, 16'h0000);
        applyStimulus(ADD, 4'd4, 4'd4, 4'd9, 16'h0000);
        checkOutput("abort_busy_before", {15'd0, bus.busy}, 16'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort_valid", {15'd0, bus.valid_out}, 16'd0);
        checkOutput("abort_busy", {15'd0, bus.busy}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_valid_after", {15'd0, bus.valid_out}, 16'd0);
        runVector(RD, 4'd9, 4'd0, 4'd0, 16'h0000, 16'h0000);
        runVector(RD, 4'd4, 4'd0, 4'd0, 16'h0000, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            runVector(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].c,
                      vecs[i].wdata, vecs[i].expd);
        end

        // en held through the busy cycle: only the first READ may execute.
        bus.en   = 1'b1;
        bus.cmd  = RD;
        bus.addA = 4'd3;
        pulses   = 0;
        @(posedge clk);
        #1;
        if (bus.valid_out) pulses++;
        checkOutput("hold_dq", dq, 16'hBEEF);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        if (bus.valid_out) pulses++;
        checkOutput("hold_busy", {15'd0, bus.busy}, 16'd0);
        @(posedge clk);
        #1;
        if (bus.valid_out) pulses++;
        checkOutput("hold_pulses", pulses[15:0], 16'd1);

        // Back-to-back writes are accepted while valid_out of the previous is high.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus.en   = 1'b1;
            bus.cmd  = WR;
            bus.addA = 4'(i);
            tb_dq    = 16'hA000 + 16'(i);
            tb_dq_en = 1'b1;
            @(posedge clk);
            #1;
            if (bus.valid_out) pulses++;
        end
        bus.en   = 1'b0;
        tb_dq_en = 1'b0;
        @(posedge clk);
        #1;
        if (bus.valid_out) pulses++;
        checkOutput("pipe_pulses", pulses[15:0], 16'd4);
        for (int i = 0; i < 4; i++) begin
            runVector(RD, 4'(i), 4'd0, 4'd0, 16'h0000, 16'hA000 + 16'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
